// File: rtl/game_flow_ctrl.sv
// Pong game sequencer: menu edge pulses, countdown, serve, play, point pause, game over.
// Optional pause state is compiled in with `define PONG_PAUSE_EN.
module game_flow_ctrl #(
  parameter int COUNT_FRAMES = 60,
  parameter int POINT_FRAMES = 45,
  parameter int OVER_FRAMES  = 300,
  parameter int WIN_SCORE    = 7,
  parameter int CNT_W        = 9
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_any,
  input  logic       btn_pause,
  input  logic [1:0] mode_choice,
  input  logic       score_event,
  input  logic [3:0] score_left,
  input  logic [3:0] score_right,
  output logic       menu_up,
  output logic       menu_down,
  output logic       start_trigger,
  output logic       menu_rst_n,
  output logic       score_clr,
  output logic       game_run,
  output logic       ball_serve,
  output logic       show_menu,
  output logic       show_winner,
  output logic [1:0] winner,
  output logic [1:0] countdown_val,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    COUNTDOWN = 3'd1,
    SERVE     = 3'd2,
    PLAY      = 3'd3,
    POINT     = 3'd4,
    OVER      = 3'd5,
    PAUSED    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       WIN_LIM    = 4'(WIN_SCORE);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]       cd_nxt;
  logic [1:0]       winner_nxt;
  logic             armed_q, armed_nxt;
  logic             prev_up, prev_down, prev_any;
  logic             up_edge, down_edge, any_edge_armed;

  assign state          = state_q;
  assign up_edge        = btn_up & ~prev_up;
  assign down_edge      = btn_down & ~prev_down;
  assign any_edge_armed = btn_any & ~prev_any & armed_q;

`ifdef PONG_PAUSE_EN
  logic prev_pause;
  logic pause_edge;
  assign pause_edge = btn_pause & ~prev_pause;
`else
  logic unused_pause;
  assign unused_pause = btn_pause;
`endif

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    cd_nxt     = countdown_val;
    winner_nxt = winner;
    case (state_q)
      MENU: begin
        if (mode_choice != 2'd0) begin
          state_nxt = COUNTDOWN;
          cnt_nxt   = '0;
          cd_nxt    = 2'd3;
        end
      end
      COUNTDOWN: begin
        if (frame_tick) begin
          if (cnt_q == COUNT_LAST) begin
            cnt_nxt = '0;
            cd_nxt  = countdown_val - 2'd1;
            if (countdown_val == 2'd1) state_nxt = SERVE;
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end
      end
      SERVE: state_nxt = PLAY;
      PLAY: begin
        // Ticks in PLAY are not counted, so POINT always starts from zero.
        if (score_event) begin
          state_nxt = POINT;
          cnt_nxt   = '0;
        end
`ifdef PONG_PAUSE_EN
        else if (pause_edge) state_nxt = PAUSED;
`endif
      end
`ifdef PONG_PAUSE_EN
      PAUSED: if (pause_edge) state_nxt = PLAY;
`endif
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            cnt_nxt = '0;
            if (score_left >= WIN_LIM) begin
              winner_nxt = 2'd1;
              state_nxt  = OVER;
            end else if (score_right >= WIN_LIM) begin
              winner_nxt = 2'd2;
              state_nxt  = OVER;
            end else begin
              state_nxt = SERVE;
            end
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end
      end
      OVER: begin
        if (any_edge_armed || (frame_tick && cnt_q == OVER_LAST)) begin
          state_nxt = MENU;
        end else if (frame_tick) begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      default: state_nxt = MENU;
    endcase
    if (state_nxt == MENU && state_q != MENU) begin
      cnt_nxt    = '0;
      cd_nxt     = 2'd0;
      winner_nxt = 2'd0;
    end
  end

  // The key that ended a game must be released before it can act again.
  always_comb begin
    armed_nxt = armed_q;
    if (state_nxt != state_q && (state_nxt == MENU || state_nxt == OVER))
      armed_nxt = 1'b0;
    else if (!btn_any)
      armed_nxt = 1'b1;
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state_q       <= MENU;
      cnt_q         <= '0;
      countdown_val <= '0;
      winner        <= '0;
      armed_q       <= 1'b0;
      prev_up       <= btn_up;
      prev_down     <= btn_down;
      prev_any      <= btn_any;
`ifdef PONG_PAUSE_EN
      prev_pause    <= btn_pause;
`endif
      menu_up       <= 1'b0;
      menu_down     <= 1'b0;
      start_trigger <= 1'b0;
      menu_rst_n    <= 1'b0;
      score_clr     <= 1'b0;
      game_run      <= 1'b0;
      ball_serve    <= 1'b0;
      show_menu     <= 1'b1;
      show_winner   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      countdown_val <= cd_nxt;
      winner        <= winner_nxt;
      armed_q       <= armed_nxt;
      prev_up       <= btn_up;
      prev_down     <= btn_down;
      prev_any      <= btn_any;
`ifdef PONG_PAUSE_EN
      prev_pause    <= btn_pause;
`endif
      menu_up       <= (state_q == MENU) && up_edge;
      menu_down     <= (state_q == MENU) && down_edge;
      start_trigger <= (state_q == MENU) && any_edge_armed;
      menu_rst_n    <= !(state_q == OVER && state_nxt == MENU);
      score_clr     <= (state_q == MENU) && (state_nxt == COUNTDOWN);
      game_run      <= (state_nxt == PLAY);
      ball_serve    <= (state_nxt == SERVE);
      show_menu     <= (state_nxt == MENU);
      show_winner   <= (state_nxt == OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with randomized tick spacing, scores and buttons.
module tb_game_flow_ctrl;
  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_any = 1'b0, btn_pause = 1'b0;
  logic [1:0] mode_choice = 2'd0;
  logic       score_event = 1'b0;
  logic [3:0] score_left = 4'd0, score_right = 4'd0;
  logic       menu_up, menu_down, start_trigger, menu_rst_n, score_clr;
  logic       game_run, ball_serve, show_menu, show_winner;
  logic [1:0] winner, countdown_val;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  always #5 clk_0 = ~clk_0;

  game_flow_ctrl #(
    .COUNT_FRAMES(60), .POINT_FRAMES(45), .OVER_FRAMES(300), .WIN_SCORE(7), .CNT_W(9)
  ) dut (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_any(btn_any), .btn_pause(btn_pause),
    .mode_choice(mode_choice), .score_event(score_event),
    .score_left(score_left), .score_right(score_right),
    .menu_up(menu_up), .menu_down(menu_down), .start_trigger(start_trigger),
    .menu_rst_n(menu_rst_n), .score_clr(score_clr), .game_run(game_run),
    .ball_serve(ball_serve), .show_menu(show_menu), .show_winner(show_winner),
    .winner(winner), .countdown_val(countdown_val), .state(state)
  );

  // Reference rule for who wins once the point pause expires.
  function automatic logic [1:0] exp_winner(input int l, input int r);
    if (l >= 7) return 2'd1;
    if (r >= 7) return 2'd2;
    return 2'd0;
  endfunction

  task automatic clk1();
    @(posedge clk_0);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    clk1();
    frame_tick = 1'b0;
  endtask

  task automatic idle_rand();
    repeat ($urandom_range(0, 3)) clk1();
  endtask

  task automatic test_reset();
    logic [13:0] got;
    rst = 1'b0;
    btn_any = 1'b1;
    repeat (2) clk1();
    got = {state, show_menu, menu_rst_n, game_run, countdown_val, winner,
           show_winner, start_trigger, score_clr, ball_serve};
    total++;
    if (got !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", got,
               {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b1;
    clk1();
    total++;
    if (menu_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_menu_rst_release got=%b exp=1", menu_rst_n);
    end
    for (int i = 0; i < 4; i++) begin
      clk1();
      total++;
      if (start_trigger !== 1'b0) begin
        bad++;
        $display("FAIL held_key_no_start cycle=%0d got=%b exp=0", i, start_trigger);
      end
    end
    btn_any = 1'b0;
    clk1();
    total++;
    if (start_trigger !== 1'b0) begin
      bad++;
      $display("FAIL release_no_start got=%b exp=0", start_trigger);
    end
    btn_any = 1'b1;
    clk1();
    total++;
    if (start_trigger !== 1'b1) begin
      bad++;
      $display("FAIL armed_press_start got=%b exp=1", start_trigger);
    end
    clk1();
    total++;
    if (start_trigger !== 1'b0) begin
      bad++;
      $display("FAIL start_one_cycle got=%b exp=0", start_trigger);
    end
    btn_any = 1'b0;
    clk1();
  endtask

  task automatic test_menu_nav();
    logic u, d;
    for (int i = 0; i < 8; i++) begin
      u = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom % 2);
      d = (i < 2) ? 1'b1 : 1'($urandom % 2);
      btn_up = u;
      btn_down = d;
      clk1();
      total++;
      if ({menu_up, menu_down} !== {u, d}) begin
        bad++;
        $display("FAIL menu_pulse i=%0d got=%b%b exp=%b%b", i, menu_up, menu_down, u, d);
      end
      clk1();
      total++;
      if ({menu_up, menu_down} !== 2'b00) begin
        bad++;
        $display("FAIL menu_pulse_held i=%0d got=%b%b exp=00", i, menu_up, menu_down);
      end
      btn_up = 1'b0;
      btn_down = 1'b0;
      clk1();
    end
  endtask

  task automatic test_countdown(input logic [1:0] mode);
    logic [4:0] exp5;
    mode_choice = mode;
    clk1();
    total++;
    if ({state, score_clr, countdown_val} !== {3'd1, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL countdown_entry got=%b exp=%b", {state, score_clr, countdown_val},
               {3'd1, 1'b1, 2'd3});
    end
    mode_choice = 2'd0;
    clk1();
    total++;
    if (score_clr !== 1'b0) begin
      bad++;
      $display("FAIL score_clr_one_cycle got=%b exp=0", score_clr);
    end
    for (int k = 1; k <= 180; k++) begin
      btn_up = 1'($urandom % 2);
      tick();
      if (k < 180) begin
        exp5 = {3'd1, 2'(3 - k / 60)};
        total++;
        if ({state, countdown_val} !== exp5 || menu_up !== 1'b0) begin
          bad++;
          $display("FAIL countdown_step k=%0d got=%b up=%b exp=%b up=0", k,
                   {state, countdown_val}, menu_up, exp5);
        end
        idle_rand();
      end else begin
        total++;
        if ({state, ball_serve, countdown_val} !== {3'd2, 1'b1, 2'd0}) begin
          bad++;
          $display("FAIL serve_after_countdown got=%b exp=%b",
                   {state, ball_serve, countdown_val}, {3'd2, 1'b1, 2'd0});
        end
      end
    end
    btn_up = 1'b0;
    clk1();
    total++;
    if ({state, game_run, ball_serve} !== {3'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL play_after_serve got=%b exp=%b", {state, game_run, ball_serve},
               {3'd3, 1'b1, 1'b0});
    end
  endtask

  task automatic test_point(input int l, input int r);
    logic [1:0] w;
    w = exp_winner(l, r);
    repeat (3) begin
      tick();
      idle_rand();
    end
    total++;
    if ({state, game_run} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL play_ignores_ticks got=%b exp=%b", {state, game_run}, {3'd3, 1'b1});
    end
    score_left = 4'(l);
    score_right = 4'(r);
    score_event = 1'b1;
    frame_tick = 1'b1;
    clk1();
    score_event = 1'b0;
    frame_tick = 1'b0;
    total++;
    if ({state, game_run} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL point_entry got=%b exp=%b", {state, game_run}, {3'd4, 1'b0});
    end
    for (int k = 1; k <= 45; k++) begin
      score_event = (k == 10);
      tick();
      score_event = 1'b0;
      if (k < 45) begin
        total++;
        if (state !== 3'd4) begin
          bad++;
          $display("FAIL point_hold k=%0d got=%0d exp=4", k, state);
        end
        idle_rand();
      end else if (w == 2'd0) begin
        total++;
        if ({state, ball_serve} !== {3'd2, 1'b1}) begin
          bad++;
          $display("FAIL point_to_serve got=%b exp=%b", {state, ball_serve}, {3'd2, 1'b1});
        end
        clk1();
        total++;
        if ({state, game_run} !== {3'd3, 1'b1}) begin
          bad++;
          $display("FAIL serve_to_play got=%b exp=%b", {state, game_run}, {3'd3, 1'b1});
        end
      end else begin
        total++;
        if ({state, winner, show_winner} !== {3'd5, w, 1'b1}) begin
          bad++;
          $display("FAIL point_to_over got=%b exp=%b", {state, winner, show_winner},
                   {3'd5, w, 1'b1});
        end
      end
    end
  endtask

  task automatic test_over_timeout();
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k < 300) begin
        total++;
        if ({state, winner} !== {3'd5, 2'd2}) begin
          bad++;
          $display("FAIL over_hold k=%0d got=%b exp=%b", k, {state, winner}, {3'd5, 2'd2});
        end
        idle_rand();
      end else begin
        total++;
        if ({state, menu_rst_n, winner, show_menu, show_winner} !==
            {3'd0, 1'b0, 2'd0, 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL over_timeout_exit got=%b exp=%b",
                   {state, menu_rst_n, winner, show_menu, show_winner},
                   {3'd0, 1'b0, 2'd0, 1'b1, 1'b0});
        end
      end
    end
    clk1();
    total++;
    if ({menu_rst_n, start_trigger} !== 2'b10) begin
      bad++;
      $display("FAIL menu_rst_one_cycle got=%b exp=10", {menu_rst_n, start_trigger});
    end
    btn_any = 1'b0;
    repeat (2) clk1();
  endtask

  task automatic test_over_early();
    repeat (5) begin
      tick();
      idle_rand();
    end
    total++;
    if ({state, winner} !== {3'd5, 2'd1}) begin
      bad++;
      $display("FAIL over_held_key got=%b exp=%b", {state, winner}, {3'd5, 2'd1});
    end
    btn_any = 1'b0;
    clk1();
    total++;
    if (state !== 3'd5) begin
      bad++;
      $display("FAIL over_release_stays got=%0d exp=5", state);
    end
    btn_any = 1'b1;
    clk1();
    total++;
    if ({state, menu_rst_n, winner, start_trigger, show_menu} !==
        {3'd0, 1'b0, 2'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL over_early_exit got=%b exp=%b",
               {state, menu_rst_n, winner, start_trigger, show_menu},
               {3'd0, 1'b0, 2'd0, 1'b0, 1'b1});
    end
    clk1();
    total++;
    if ({menu_rst_n, start_trigger} !== 2'b10) begin
      bad++;
      $display("FAIL early_exit_no_start got=%b exp=10", {menu_rst_n, start_trigger});
    end
    btn_any = 1'b0;
    repeat (2) clk1();
  endtask

  task automatic test_midreset();
    mode_choice = 2'd2;
    clk1();
    mode_choice = 2'd0;
    repeat ($urandom_range(1, 100)) begin
      tick();
      idle_rand();
    end
    rst = 1'b0;
    clk1();
    total++;
    if ({state, countdown_val, show_menu, menu_rst_n, game_run} !==
        {3'd0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset got=%b exp=%b",
               {state, countdown_val, show_menu, menu_rst_n, game_run},
               {3'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    end
    rst = 1'b1;
    clk1();
    total++;
    if ({state, menu_rst_n} !== {3'd0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_release got=%b exp=%b", {state, menu_rst_n}, {3'd0, 1'b1});
    end
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause();
    test_countdown(2'd2);
    btn_pause = 1'b1;
    clk1();
    total++;
    if ({state, game_run} !== {3'd6, 1'b0}) begin
      bad++;
      $display("FAIL pause_entry got=%b exp=%b", {state, game_run}, {3'd6, 1'b0});
    end
    score_right = 4'd7;
    score_event = 1'b1;
    clk1();
    score_event = 1'b0;
    btn_pause = 1'b0;
    clk1();
    total++;
    if (state !== 3'd6) begin
      bad++;
      $display("FAIL pause_ignores_score got=%0d exp=6", state);
    end
    btn_pause = 1'b1;
    clk1();
    btn_pause = 1'b0;
    total++;
    if ({state, game_run} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL pause_exit got=%b exp=%b", {state, game_run}, {3'd3, 1'b1});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_menu_nav();
    test_countdown(2'd2);
    test_point(3, int'($urandom_range(0, 6)));
    test_point(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
    btn_any = 1'b1;
    test_point(int'($urandom_range(0, 6)), 7);
    test_over_timeout();
    test_countdown(2'd1);
    btn_any = 1'b1;
    test_point(7, int'($urandom_range(0, 7)));
    test_over_early();
    test_midreset();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the Pong console. It turns raw button levels into the edge pulses the start menu consumes (up/down/start_trigger), waits for the menu's mode lock-in, then runs the game through countdown, serve, play, point pause and game-over. On game-over it returns to the menu and re-arms it. It drives the layer selects for the pixel mux and the run/serve enables for the ball and paddle logic.

Parameters:
COUNT_FRAMES, 60, frames per countdown step (3,2,1)
POINT_FRAMES, 45, frames of pause after each point
OVER_FRAMES, 300, frames the winner screen is held before auto-return to menu
WIN_SCORE, 7, score that ends the game (4-bit compare)
CNT_W, 9, frame counter width; must hold max(COUNT_FRAMES, POINT_FRAMES, OVER_FRAMES)

Ports:
clk_0 input 1 system pixel clock
rst input 1 reset, synchronous, active-low
frame_tick input 1 one-cycle pulse per video frame
btn_up input 1 synchronised up button level
btn_down input 1 synchronised down button level
btn_any input 1 synchronised OR of all player keys, level
btn_pause input 1 synchronised pause key level (used only with PONG_PAUSE_EN)
mode_choice input 2 from start menu: 0 none, 1 single, 2 multi
score_event input 1 one-cycle pulse when either side scores
score_left input 4 left score, already updated on the score_event edge
score_right input 4 right score, already updated on the score_event edge
menu_up output 1 one-cycle pulse on btn_up rising edge, MENU only
menu_down output 1 one-cycle pulse on btn_down rising edge, MENU only
start_trigger output 1 one-cycle pulse on armed btn_any rising edge, MENU only
menu_rst_n output 1 active-low, one-cycle reset to start menu (clears mode_choice)
score_clr output 1 one-cycle pulse clearing score counters on new game
game_run output 1 high in PLAY: enables ball and paddle motion
ball_serve output 1 one-cycle pulse: recenter and launch ball
show_menu output 1 menu layer select
show_winner output 1 winner overlay select
winner output 2 0 none, 1 left, 2 right
countdown_val output 2 countdown digit 3..1, 0 otherwise
state output 3 current state encoding

Behaviour:
- States: MENU=0, COUNTDOWN=1, SERVE=2, PLAY=3, POINT=4, OVER=5, PAUSED=6 (macro only). Encodings 7 and 6 (without macro) go to MENU next cycle.
- Reset (rst low at clk_0 edge): state MENU, all pulse outputs 0, menu_rst_n 0 for the reset cycle, game_run 0, show_menu 1, show_winner 0, winner 0, countdown_val 0, frame counter 0, armed 0, edge-detect registers load current button levels (no spurious edge out of reset).
- Edge detect: a registered previous level per button. Pulse = level & ~prev. Output pulses are registered, 1 cycle after the edge cycle.
- armed: cleared on MENU and OVER entry. Set when btn_any is sampled low. A btn_any edge counts only if armed. This prevents the key that ended the game from also starting a new one.
- MENU: show_menu=1. It emits menu_up, menu_down and start_trigger. When mode_choice!=0 is seen, the next state is COUNTDOWN, with a score_clr pulse and countdown_val=3. If up and down edges occur together, both pulses are issued; the menu gives up priority.
- COUNTDOWN: the counter increments on each frame_tick. At COUNT_FRAMES-1 plus a tick, the counter goes to 0 and countdown_val decrements. When it goes 1 to 0, the next state is SERVE.
- SERVE: lasts exactly 1 cycle. ball_serve=1, then PLAY.
- PLAY: game_run=1. score_event moves to POINT with the counter cleared. A frame_tick in the same cycle is not counted.
- POINT: game_run=0. After POINT_FRAMES ticks: if score_left>=WIN_SCORE, winner=1 and go to OVER. Else if score_right>=WIN_SCORE, winner=2 and go to OVER. Else go to SERVE. Left is checked first if both scores reach the limit.
- OVER: show_winner=1. The state ends on OVER_FRAMES ticks or on an armed btn_any edge, whichever comes first. Exit goes to MENU with menu_rst_n=0 for 1 cycle, winner held until MENU entry then cleared, and show_menu=1.
- score_event outside PLAY is ignored. A frame counter reload and a tick in the same cycle give the reload priority.

Optional Feature:
PONG_PAUSE_EN: in PLAY, a btn_pause rising edge goes to PAUSED with game_run=0. Another edge returns to PLAY. score_event is ignored while PAUSED. Without the macro, btn_pause is unused and the PAUSED state is never entered.

Test Plan:
- Reset with btn_any held high, then release and press: no start_trigger until the first low; start_trigger asserts 1 cycle after the press edge.
- btn_down edge in MENU -> one menu_down pulse. Then mode_choice=2 -> COUNTDOWN with score_clr pulse and countdown_val 3,2,1 every 60 ticks. SERVE ball_serve pulse follows on tick 180.
- PLAY, score_event with score_left=3 -> game_run drops next cycle, 45 ticks of POINT, ball_serve pulse, back in PLAY.
- score_event with score_right=7 -> after 45 ticks OVER with winner=2. Then 300 ticks -> MENU, menu_rst_n low 1 cycle, winner=0.
- OVER entered with btn_any held high: release then press -> early MENU return. Key held throughout -> return only after 300 ticks.
- rst low mid-COUNTDOWN -> next cycle state=0, countdown_val=0, show_menu=1. With PONG_PAUSE_EN: pause edge in PLAY -> state 6; score_event ignored; second edge -> PLAY.
